alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter DW, default 8, datapath width in bits.
REQ-002 Parameter NREG, default 4, number of register-file entries; AW = log2(NREG) = 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ld_valid  input  1  register-load request.
REQ-006 ld_addr  input  AW  load target register.
REQ-007 ld_data  input  DW  load value.
REQ-008 ld_ready  output  1  load accepted this cycle.
REQ-009 op_valid  input  1  operation request.
REQ-010 op_code  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1 (A only), 6 SHR1 (A only).
REQ-011 op_dst, op_srca, op_srcb  input  AW each  destination and source register indices.
REQ-012 op_ready  output  1  operation accepted this cycle.
REQ-013 res_valid  output  1  one-cycle result strobe.
REQ-014 res_data  output  DW  result value.
REQ-015 res_flag  output  4  one-hot flags: 1000 carry, 0100 negative, 0010 zero, 0001 illegal, 0000 none.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, READ, EXEC and WB, with transitions IDLE->READ on op accept, READ->EXEC, EXEC->WB and WB->IDLE, each unconditional.
REQ-018 Handshakes: transfer occurs when valid and ready are both high; ld_ready and op_ready SHALL be high only in IDLE.
REQ-019 If ld_valid and op_valid are both high in IDLE, the load SHALL win: ld_ready=1, op_ready=0, and the op waits.
REQ-020 Op accept cycle T latches opcode and indices; READ (T+1) latches the operand registers; EXEC (T+2) registers the ALU result and flag; WB (T+3) asserts res_valid and writes res_data to op_dst at the end of T+3.
REQ-021 Latency from accept to res_valid SHALL be 3 cycles; maximum throughput SHALL be one op per 4 cycles.
REQ-022 ADD: result = (A+B) mod 2^DW; flag = 1000 if the DW-bit carry-out is set, else 0010 if the result is 0, else 0000.
REQ-023 SUB: result = (A-B) mod 2^DW; flag = 0100 if A<B (unsigned), 0010 if A==B, else 0000.
REQ-024 AND, OR, XOR, SHL1, SHR1: flag = 0010 if the result is 0, else 0000; flag SHALL never hold over from a previous op.
REQ-025 Opcodes 7-15: res_valid SHALL still pulse at T+3 with res_data = 0 and res_flag = 0001, and no register write SHALL occur.
REQ-026 op_dst equal to op_srca or op_srcb SHALL be legal; sources are read in READ, before the WB write.
REQ-027 res_data and res_flag SHALL hold their last values until the next WB; res_valid SHALL be high only in WB.
REQ-028 A load SHALL write the register-file entry at the end of its accept cycle.

Reset
REQ-029 While rst_n=0, regardless of state: FSM=IDLE, all registers=0, res_valid=0, res_data=0, res_flag=0000, busy=0, op_ready=0, ld_ready=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no writeback and no res_valid.
REQ-031 op_ready and ld_ready SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode constants, the flag encodings (FLAG_CARRY, FLAG_NEG, FLAG_ZERO, FLAG_ILL, FLAG_NONE) and the FSM state enum.
REQ-033 The combinational ALU SHALL be a sub-module alu_core (a, b, opcode -> result, flag), instantiated once in the controller.
REQ-034 The register file SHALL be inline in alu_seq_ctrl.

Verification
REQ-035 Load r0=0xF0, r1=0x20, then op ADD dst=r2 a=r0 b=r1 at T -> res_valid at T+3, res_data=0x10, res_flag=1000, r2=0x10.
REQ-036 SUB a=r1(0x20) b=r0(0xF0) -> res_data=0x30, res_flag=0100; SUB a=r0 b=r0 -> 0x00, 0010.
REQ-037 op_code=0x9 -> res_valid at T+3, res_data=0x00, res_flag=0001, destination register unchanged.
REQ-038 op_valid held high for 3 ops -> op_ready high at T, T+4 and T+8; busy low only on those cycles.
REQ-039 ld_valid and op_valid together in IDLE -> load accepted first, op accepted next cycle.
REQ-040 rst_n pulsed low during EXEC -> no res_valid, all registers read back 0, op_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequenced ALU controller: opcodes, one-hot result
// flags and the controller FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL1 = 4'd5;
   localparam logic [3:0] OP_SHR1 = 4'd6;

   localparam logic [3:0] FLAG_CARRY = 4'b1000;
   localparam logic [3:0] FLAG_NEG   = 4'b0100;
   localparam logic [3:0] FLAG_ZERO  = 4'b0010;
   localparam logic [3:0] FLAG_ILL   = 4'b0001;
   localparam logic [3:0] FLAG_NONE  = 4'b0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } state_t;

   // Opcodes above SHR1 are reserved and must never write the register file.
   function automatic logic isLegalOp(input logic [3:0] code);
      return (code <= OP_SHR1);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: computes result and one-hot flag from two operands.
module alu_core
   import alu_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [3:0]    opcode,
   output logic [DW-1:0] result,
   output logic [3:0]    flag
);

   logic [DW:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b};

   // Carry takes priority over zero for ADD, so 0xF0+0x10 reports carry.
   always_comb begin
      result = '0;
      flag   = FLAG_NONE;
      case (opcode)
         OP_ADD: begin
            result = w_sum[DW-1:0];
            if (w_sum[DW])         flag = FLAG_CARRY;
            else if (result == '0) flag = FLAG_ZERO;
         end
         OP_SUB: begin
            result = a - b;
            if (a < b)       flag = FLAG_NEG;
            else if (a == b) flag = FLAG_ZERO;
         end
         OP_AND, OP_OR, OP_XOR, OP_SHL1, OP_SHR1: begin
            case (opcode)
               OP_AND:  result = a & b;
               OP_OR:   result = a | b;
               OP_XOR:  result = a ^ b;
               OP_SHL1: result = {a[DW-2:0], 1'b0};
               default: result = {1'b0, a[DW-1:1]};
            endcase
            flag = (result == '0) ? FLAG_ZERO : FLAG_NONE;
         end
         default: begin
            result = '0;
            flag   = FLAG_ILL;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state sequenced ALU controller with an inline register file; loads take
// priority over operations and each operation takes four cycles end to end.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter  int DW   = 8,
   parameter  int NREG = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   input  logic          op_valid,
   input  logic [3:0]    op_code,
   input  logic [AW-1:0] op_dst,
   input  logic [AW-1:0] op_srca,
   input  logic [AW-1:0] op_srcb,
   output logic          op_ready,
   output logic          res_valid,
   output logic [DW-1:0] res_data,
   output logic [3:0]    res_flag,
   output logic          busy
);

   state_t        r_state;
   state_t        w_nextState;
   logic [3:0]    r_opCode;
   logic [AW-1:0] r_dst;
   logic [AW-1:0] r_srcA;
   logic [AW-1:0] r_srcB;
   logic [DW-1:0] r_opA;
   logic [DW-1:0] r_opB;
   logic [DW-1:0] r_resData;
   logic [3:0]    r_resFlag;
   logic [DW-1:0] r_regs [NREG];

   logic          w_idle;
   logic          w_ldFire;
   logic          w_opFire;
   logic [DW-1:0] w_aluResult;
   logic [3:0]    w_aluFlag;

   // Readies are gated by rst_n so they stay low for the whole reset window.
   assign w_idle    = (r_state == ST_IDLE);
   assign ld_ready  = w_idle & rst_n;
   assign op_ready  = w_idle & rst_n & ~ld_valid;
   assign w_ldFire  = ld_valid & ld_ready;
   assign w_opFire  = op_valid & op_ready;
   assign busy      = ~w_idle;
   assign res_valid = (r_state == ST_WB);
   assign res_data  = r_resData;
   assign res_flag  = r_resFlag;

   alu_core #(.DW(DW)) u_alu (
      .a      (r_opA),
      .b      (r_opB),
      .opcode (r_opCode),
      .result (w_aluResult),
      .flag   (w_aluFlag)
   );

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_opFire) w_nextState = ST_READ;
         ST_READ: w_nextState = ST_EXEC;
         ST_EXEC: w_nextState = ST_WB;
         ST_WB:   w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_opCode  <= '0;
         r_dst     <= '0;
         r_srcA    <= '0;
         r_srcB    <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_resData <= '0;
         r_resFlag <= FLAG_NONE;
      end else begin
         r_state <= w_nextState;
         if (w_opFire) begin
            r_opCode <= op_code;
            r_dst    <= op_dst;
            r_srcA   <= op_srca;
            r_srcB   <= op_srcb;
         end
         if (r_state == ST_READ) begin
            r_opA <= r_regs[r_srcA];
            r_opB <= r_regs[r_srcB];
         end
         if (r_state == ST_EXEC) begin
            r_resData <= w_aluResult;
            r_resFlag <= w_aluFlag;
         end
      end
   end

   // Loads and writebacks can never coincide: loads only fire in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_ldFire) begin
         r_regs[ld_addr] <= ld_data;
      end else if ((r_state == ST_WB) && isLegalOp(r_opCode)) begin
         r_regs[r_dst] <= r_resData;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with hand-computed vectors.
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       ld_valid;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       op_valid;
   logic [3:0] op_code;
   logic [1:0] op_dst;
   logic [1:0] op_srca;
   logic [1:0] op_srcb;
   logic       op_ready;
   logic       res_valid;
   logic [7:0] res_data;
   logic [3:0] res_flag;
   logic       busy;

   int nChecks = 0;
   int nPass   = 0;

   alu_seq_ctrl #(.DW(8), .NREG(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .op_valid  (op_valid),
      .op_code   (op_code),
      .op_dst    (op_dst),
      .op_srca   (op_srca),
      .op_srcb   (op_srcb),
      .op_ready  (op_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_flag  (res_flag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      tick();
      ld_valid = 1'b0;
   endtask

   // Issues one op from IDLE; lat counts cycles from accept to res_valid.
   task automatic run_op(input logic [3:0] code, input logic [1:0] dst,
                         input logic [1:0] a, input logic [1:0] b,
                         output logic acc, output int lat,
                         output logic [7:0] data, output logic [3:0] flag);
      op_valid = 1'b1;
      op_code  = code;
      op_dst   = dst;
      op_srca  = a;
      op_srcb  = b;
      #1;
      acc = op_ready;
      tick();
      op_valid = 1'b0;
      lat = 1;
      while (res_valid !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      data = res_data;
      flag = res_flag;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      nChecks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else nPass++;
      nChecks++; if (op_ready !== 1'b0 || ld_ready !== 1'b0) $display("[TB] FAIL rst_ready: got op=%b ld=%b want 0 0", op_ready, ld_ready); else nPass++;
      nChecks++; if (res_valid !== 1'b0 || res_data !== 8'h00 || res_flag !== 4'b0000) $display("[TB] FAIL rst_res: got v=%b d=%h f=%b want 0 00 0000", res_valid, res_data, res_flag); else nPass++;
      rst_n = 1'b1;
      #1;
      nChecks++; if (op_ready !== 1'b1 || ld_ready !== 1'b1) $display("[TB] FAIL rst_release_ready: got op=%b ld=%b want 1 1", op_ready, ld_ready); else nPass++;
      tick();
   endtask

   task automatic test_add;
      logic acc; int lat; logic [7:0] d; logic [3:0] f;
      do_load(2'd0, 8'hF0);
      do_load(2'd1, 8'h20);
      run_op(4'd0, 2'd2, 2'd0, 2'd1, acc, lat, d, f);
      nChecks++; if (acc !== 1'b1) $display("[TB] FAIL add_accept: got %b want 1", acc); else nPass++;
      nChecks++; if (lat != 3) $display("[TB] FAIL add_latency: got %0d want 3", lat); else nPass++;
      nChecks++; if (d !== 8'h10 || f !== 4'b1000) $display("[TB] FAIL add_result: got %h/%b want 10/1000", d, f); else nPass++;
      nChecks++; if (res_valid !== 1'b0 || res_data !== 8'h10 || res_flag !== 4'b1000) $display("[TB] FAIL add_hold: got v=%b d=%h f=%b want 0 10 1000", res_valid, res_data, res_flag); else nPass++;
      run_op(4'd3, 2'd2, 2'd2, 2'd2, acc, lat, d, f);
      nChecks++; if (d !== 8'h10 || f !== 4'b0000) $display("[TB] FAIL add_r2_readback: got %h/%b want 10/0000", d, f); else nPass++;
      run_op(4'd0, 2'd3, 2'd0, 2'd2, acc, lat, d, f);
      nChecks++; if (d !== 8'h00 || f !== 4'b1000) $display("[TB] FAIL add_carry_zero: got %h/%b want 00/1000", d, f); else nPass++;
   endtask

   task automatic test_sub;
      logic acc; int lat; logic [7:0] d; logic [3:0] f;
      run_op(4'd1, 2'd3, 2'd1, 2'd0, acc, lat, d, f);
      nChecks++; if (d !== 8'h30 || f !== 4'b0100) $display("[TB] FAIL sub_neg: got %h/%b want 30/0100", d, f); else nPass++;
      run_op(4'd1, 2'd3, 2'd0, 2'd0, acc, lat, d, f);
      nChecks++; if (d !== 8'h00 || f !== 4'b0010) $display("[TB] FAIL sub_eq: got %h/%b want 00/0010", d, f); else nPass++;
      run_op(4'd1, 2'd3, 2'd0, 2'd1, acc, lat, d, f);
      nChecks++; if (d !== 8'hD0 || f !== 4'b0000) $display("[TB] FAIL sub_pos: got %h/%b want d0/0000", d, f); else nPass++;
   endtask

   task automatic test_logic;
      logic acc; int lat; logic [7:0] d; logic [3:0] f;
      logic [3:0]  codes [5] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd3};
      logic [1:0]  srcA  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
      logic [1:0]  srcB  [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
      logic [7:0]  expD  [5] = '{8'h20, 8'h00, 8'hE0, 8'h10, 8'hF0};
      logic [3:0]  expF  [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 5; i++) begin
         run_op(codes[i], 2'd3, srcA[i], srcB[i], acc, lat, d, f);
         nChecks++; if (d !== expD[i] || f !== expF[i]) $display("[TB] FAIL logic_op%0d: got %h/%b want %h/%b", codes[i], d, f, expD[i], expF[i]); else nPass++;
      end
   endtask

   task automatic test_illegal;
      logic acc; int lat; logic [7:0] d; logic [3:0] f;
      run_op(4'd9, 2'd2, 2'd0, 2'd1, acc, lat, d, f);
      nChecks++; if (lat != 3) $display("[TB] FAIL ill_latency: got %0d want 3", lat); else nPass++;
      nChecks++; if (d !== 8'h00 || f !== 4'b0001) $display("[TB] FAIL ill_result: got %h/%b want 00/0001", d, f); else nPass++;
      run_op(4'd15, 2'd2, 2'd0, 2'd0, acc, lat, d, f);
      nChecks++; if (d !== 8'h00 || f !== 4'b0001) $display("[TB] FAIL ill15_result: got %h/%b want 00/0001", d, f); else nPass++;
      run_op(4'd3, 2'd2, 2'd2, 2'd2, acc, lat, d, f);
      nChecks++; if (d !== 8'h10) $display("[TB] FAIL ill_no_write: got r2=%h want 10", d); else nPass++;
   endtask

   task automatic test_back_to_back;
      int nRes = 0;
      int nBad = 0;
      op_valid = 1'b1;
      op_code  = 4'd3;
      op_dst   = 2'd3;
      op_srca  = 2'd1;
      op_srcb  = 2'd1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (op_ready !== (i % 4 == 0) || busy !== (i % 4 != 0)) begin
            nBad++;
            $display("[TB] FAIL b2b_cycle%0d: got op_ready=%b busy=%b want %b %b", i, op_ready, busy, (i % 4 == 0), (i % 4 != 0));
         end
         if (res_valid === 1'b1) nRes++;
         tick();
         if (i == 8) op_valid = 1'b0;
      end
      nChecks++; if (nBad != 0) $display("[TB] FAIL b2b_pattern: got %0d bad cycles want 0", nBad); else nPass++;
      nChecks++; if (nRes != 3) $display("[TB] FAIL b2b_results: got %0d want 3", nRes); else nPass++;
      nChecks++; if (res_data !== 8'h20) $display("[TB] FAIL b2b_data: got %h want 20", res_data); else nPass++;
   endtask

   task automatic test_ld_priority;
      int lat;
      ld_valid = 1'b1;
      ld_addr  = 2'd3;
      ld_data  = 8'h55;
      op_valid = 1'b1;
      op_code  = 4'd3;
      op_dst   = 2'd3;
      op_srca  = 2'd3;
      op_srcb  = 2'd3;
      #1;
      nChecks++; if (ld_ready !== 1'b1 || op_ready !== 1'b0) $display("[TB] FAIL prio_first: got ld=%b op=%b want 1 0", ld_ready, op_ready); else nPass++;
      tick();
      ld_valid = 1'b0;
      #1;
      nChecks++; if (op_ready !== 1'b1) $display("[TB] FAIL prio_second: got op_ready=%b want 1", op_ready); else nPass++;
      tick();
      op_valid = 1'b0;
      lat = 1;
      while (res_valid !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      nChecks++; if (lat != 3 || res_data !== 8'h55) $display("[TB] FAIL prio_result: got lat=%0d d=%h want 3 55", lat, res_data); else nPass++;
      tick();
   endtask

   task automatic test_reset_mid;
      logic acc; int lat; logic [7:0] d; logic [3:0] f;
      logic sawValid = 1'b0;
      op_valid = 1'b1;
      op_code  = 4'd0;
      op_dst   = 2'd3;
      op_srca  = 2'd0;
      op_srcb  = 2'd1;
      tick();
      op_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      nChecks++; if (busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0) $display("[TB] FAIL midrst_state: got busy=%b v=%b op=%b want 0 0 0", busy, res_valid, op_ready); else nPass++;
      nChecks++; if (res_data !== 8'h00 || res_flag !== 4'b0000) $display("[TB] FAIL midrst_res: got %h/%b want 00/0000", res_data, res_flag); else nPass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (res_valid === 1'b1) sawValid = 1'b1;
      end
      rst_n = 1'b1;
      #1;
      nChecks++; if (op_ready !== 1'b1) $display("[TB] FAIL midrst_release: got op_ready=%b want 1", op_ready); else nPass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (res_valid === 1'b1) sawValid = 1'b1;
      end
      nChecks++; if (sawValid !== 1'b0) $display("[TB] FAIL midrst_no_valid: got res_valid pulse want none"); else nPass++;
      for (int r = 0; r < 4; r++) begin
         run_op(4'd3, r[1:0], r[1:0], r[1:0], acc, lat, d, f);
         nChecks++; if (d !== 8'h00 || f !== 4'b0010) $display("[TB] FAIL midrst_r%0d: got %h/%b want 00/0010", r, d, f); else nPass++;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      ld_valid = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;
      op_valid = 1'b0;
      op_code  = '0;
      op_dst   = '0;
      op_srca  = '0;
      op_srcb  = '0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_illegal();
      test_back_to_back();
      test_ld_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
